// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC gain-compensation pipeline.
// Holds the per-beat gain mode encoding and the shift/sign table of the
// fixed shift-sum approximation of the CORDIC gain 0.6072998.
package cordic_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_COMP   = 2'b01,
    MODE_COMP2  = 2'b10,
    MODE_RSVD   = 2'b11   // behaves as bypass
  } gain_mode_e;

  // Gain = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13
  localparam int NUM_TERMS = 5;
  localparam int TERM_SHIFT [NUM_TERMS] = '{1, 3, 6, 9, 13};
  localparam bit TERM_NEG   [NUM_TERMS] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  // True for the modes that apply the shift-sum; everything else passes through.
  function automatic logic is_comp(input gain_mode_e m);
    return (m == MODE_COMP) || (m == MODE_COMP2);
  endfunction

endpackage

// File: rtl/gain_comp_lane.sv
// One channel of the gain-compensation datapath: shift-sum partials (stage 1),
// then round-half-up and saturate (stage 2). Load enables come from the top.
// Ports: clk/rst, ld1_i/ld2_i stage load strobes, mode_i (input beat mode),
//        mode_s1_i (mode held in stage 1), din_i sample, dout_o/sat_o result.
module gain_comp_lane
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int GUARD_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld1_i,
  input  logic                         ld2_i,
  input  gain_mode_e                   mode_i,
  input  gain_mode_e                   mode_s1_i,
  input  logic signed [DATA_WIDTH-1:0] din_i,
  output logic signed [DATA_WIDTH-1:0] dout_o,
  output logic                         sat_o
);

  localparam int DW = DATA_WIDTH;
  localparam int GB = GUARD_BITS;
  // Two headroom bits cover the x2 gain (peak partial sum 1.25x the input).
  localparam int AW = DW + GB + 2;

  localparam logic signed [AW-1:0] HALF = {{(AW-1){1'b0}}, 1'b1} << (GB - 1);
  localparam logic signed [AW-1:0] MAXV = {{(GB+3){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(GB+3){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] pos_d, neg_d, pos_q, neg_q;
  logic signed [AW-1:0] diff, rnd;
  logic signed [DW-1:0] dout_d, dout_q;
  logic                 sat_d, sat_q;

  // Sign-extend to the accumulator width and open up the guard fraction bits.
  assign ext = {{2{din_i[DW-1]}}, din_i, {GB{1'b0}}};

  // Stage 1: positive and negative term sums kept separate.
  always_comb begin
    pos_d = '0;
    neg_d = '0;
    term  = '0;
    if (is_comp(mode_i)) begin
      for (int i = 0; i < NUM_TERMS; i++) begin
        // x2 gain is the same table with every shift one smaller.
        if (mode_i == MODE_COMP2) term = ext >>> (TERM_SHIFT[i] - 1);
        else                      term = ext >>> TERM_SHIFT[i];
        if (TERM_NEG[i]) neg_d = neg_d + term;
        else             pos_d = pos_d + term;
      end
    end else begin
      pos_d = ext;
    end
  end

  // Stage 2: combine, round half toward +inf, clip to the output range.
  always_comb begin
    diff   = pos_q - neg_q;
    rnd    = (diff + HALF) >>> GB;
    dout_d = rnd[DW-1:0];
    sat_d  = 1'b0;
    if (!is_comp(mode_s1_i)) begin
      dout_d = pos_q[GB+DW-1:GB];
    end else if (rnd > MAXV) begin
      dout_d = MAXV[DW-1:0];
      sat_d  = 1'b1;
    end else if (rnd < MINV) begin
      dout_d = MINV[DW-1:0];
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      neg_q <= '0;
    end else if (ld1_i) begin
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else if (ld2_i) begin
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign dout_o = dout_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/gain_comp_pipe.sv
// CORDIC gain compensation: two-stage valid/ready pipeline scaling x/y by a
// per-beat selectable gain (bypass, 0.6073, 1.2146) with saturation flag.
// Ports: clk/rst, in_valid/in_ready + x_in/y_in/mode, out_valid/out_ready +
//        x_out/y_out/sat_out. Latency 2, one beat per cycle, stalls hold output.
module gain_comp_pipe
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int GUARD_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic [1:0]                   mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         sat_out
);

  logic       adv;
  logic       ld1, ld2;
  logic       s1_vld_d, s1_vld_q;
  logic       out_vld_d, out_vld_q;
  gain_mode_e mode_in, mode_q;
  logic       sat_x, sat_y;

  // Whole pipe moves together whenever the output slot is free or draining,
  // which also squeezes out any bubble sitting in front of a valid beat.
  assign adv      = !out_vld_q || out_ready;
  assign in_ready = adv;

  assign ld1 = adv && in_valid;
  assign ld2 = adv && s1_vld_q;

  assign s1_vld_d  = adv ? in_valid : s1_vld_q;
  assign out_vld_d = adv ? s1_vld_q : out_vld_q;

  assign mode_in = gain_mode_e'(mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      mode_q <= MODE_BYPASS;
    else if (ld1) mode_q <= mode_in;
  end

  gain_comp_lane #(.DATA_WIDTH(DATA_WIDTH), .GUARD_BITS(GUARD_BITS)) u_lane_x (
    .clk       (clk),
    .rst       (rst),
    .ld1_i     (ld1),
    .ld2_i     (ld2),
    .mode_i    (mode_in),
    .mode_s1_i (mode_q),
    .din_i     (x_in),
    .dout_o    (x_out),
    .sat_o     (sat_x)
  );

  gain_comp_lane #(.DATA_WIDTH(DATA_WIDTH), .GUARD_BITS(GUARD_BITS)) u_lane_y (
    .clk       (clk),
    .rst       (rst),
    .ld1_i     (ld1),
    .ld2_i     (ld2),
    .mode_i    (mode_in),
    .mode_s1_i (mode_q),
    .din_i     (y_in),
    .dout_o    (y_out),
    .sat_o     (sat_y)
  );

  assign out_valid = out_vld_q;
  assign sat_out   = sat_x || sat_y;

endmodule

// File: tb/tb_gain_comp_pipe.sv
// Bench for gain_comp_pipe: directed known-answer beats, a randomized stream
// with random output stalls against an arithmetic reference model, and reset.
// Uses a 14-bit instance for most steps and a 16-bit instance for one case.
module tb_gain_comp_pipe;

  localparam int DW = 14;
  localparam int GB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 in_valid, in_ready, out_valid, out_ready, sat_out;
  logic signed [DW-1:0] x_in, y_in, x_out, y_out;
  logic [1:0]           mode;

  logic                 in_valid16, in_ready16, out_valid16, sat_out16;
  logic signed [15:0]   x_in16, y_in16, x_out16, y_out16;
  logic [1:0]           mode16;

  gain_comp_pipe #(.DATA_WIDTH(DW), .GUARD_BITS(GB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .sat_out(sat_out)
  );

  gain_comp_pipe #(.DATA_WIDTH(16), .GUARD_BITS(GB)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .x_in(x_in16), .y_in(y_in16), .mode(mode16), .out_valid(out_valid16),
    .out_ready(out_ready), .x_out(x_out16), .y_out(y_out16), .sat_out(sat_out16)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: scale by the gain as a sum of floored power-of-two fractions
  // on a value carrying GB fraction bits, round half up, clip to dw bits.
  function automatic int ref_scale(input int m, input int v, input int dw,
                                   output bit sat);
    int sh [5] = '{1, 3, 6, 9, 13};
    int sg [5] = '{1, 1, -1, -1, -1};
    int acc, r, lim;
    sat = 1'b0;
    if (m != 1 && m != 2) return v;
    acc = 0;
    for (int i = 0; i < 5; i++)
      acc += sg[i] * ((v * (1 << GB)) >>> (sh[i] - ((m == 2) ? 1 : 0)));
    r   = (acc + (1 << (GB - 1))) >>> GB;
    lim = 1 << (dw - 1);
    if (r > lim - 1) begin sat = 1'b1; return lim - 1; end
    if (r < -lim)    begin sat = 1'b1; return -lim;    end
    return r;
  endfunction

  // One beat with out_ready high: not visible after one edge, visible after two.
  task automatic directed(input string tag, input logic [1:0] m, input int x,
                          input int y, input int ex, input int ey, input bit es);
    @(negedge clk);
    in_valid = 1'b1; mode = m; x_in = DW'(x); y_in = DW'(y);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1_valid"}, 32'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_x"}, 32'($signed(x_out)), ex);
    chk({tag, "_y"}, 32'($signed(y_out)), ey);
    chk({tag, "_sat"}, 32'(sat_out), 32'(es));
  endtask

  int qx[$], qy[$];
  bit qs[$];
  int sent, popped, cycles;
  bit stalled;
  logic signed [DW-1:0] hx, hy;
  logic hs;
  int vx, vy, vm, ex, ey;
  bit sx, sy;

  initial begin
    rst = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0; mode = 2'b00; out_ready = 1'b1;
    in_valid16 = 1'b0; x_in16 = '0; y_in16 = '0; mode16 = 2'b00;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_x_out", 32'($signed(x_out)), 0);
    chk("rst_sat_out", 32'(sat_out), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Known-answer beats.
    directed("comp_1000",  2'b01, 1000, -1000, 607, -607, 1'b0);
    directed("comp2_sat",  2'b10, 8191, -8192, 8191, -8192, 1'b1);
    directed("bypass_00",  2'b00, 1234, -5, 1234, -5, 1'b0);
    directed("bypass_11",  2'b11, 1234, -5, 1234, -5, 1'b0);

    // 16-bit instance: 8192 * 0.6073 -> 4975.
    @(negedge clk);
    in_valid16 = 1'b1; mode16 = 2'b01; x_in16 = 16'sd8192; y_in16 = -16'sd8192;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("w16_valid", 32'(out_valid16), 1);
    chk("w16_x", 32'($signed(x_out16)), 4975);
    chk("w16_y", 32'($signed(y_out16)), -4975);
    chk("w16_sat", 32'(sat_out16), 0);

    // Randomized stream with random backpressure.
    @(posedge clk);
    sent = 0; popped = 0; cycles = 0; stalled = 1'b0;
    while ((popped < 20) && (cycles < 600)) begin
      @(negedge clk);
      cycles++;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_x", 32'($signed(x_out)), 32'(hx));
        chk("stall_y", 32'($signed(y_out)), 32'(hy));
        chk("stall_sat", 32'(sat_out), 32'(hs));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (qx.size() == 0) begin
          chk("stream_unexpected_beat", 32'(popped), -1);
        end else begin
          chk("stream_x", 32'($signed(x_out)), qx.pop_front());
          chk("stream_y", 32'($signed(y_out)), qy.pop_front());
          chk("stream_sat", 32'(sat_out), 32'(qs.pop_front()));
          popped++;
        end
      end
      stalled = out_valid && !out_ready;
      hx = x_out; hy = y_out; hs = sat_out;
      if ((sent < 20) && ($urandom_range(0, 3) != 0)) begin
        vx = int'($urandom_range(0, 16383)) - 8192;
        vy = int'($urandom_range(0, 16383)) - 8192;
        vm = int'($urandom_range(0, 3));
        in_valid = 1'b1; mode = 2'(vm); x_in = DW'(vx); y_in = DW'(vy);
        if (in_ready) begin
          ex = ref_scale(vm, vx, DW, sx);
          ey = ref_scale(vm, vy, DW, sy);
          qx.push_back(ex); qy.push_back(ey); qs.push_back(sx | sy);
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream_count", 32'(popped), 20);
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset with two beats in flight.
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b01; x_in = 14'sd1000; y_in = 14'sd1000;
    @(negedge clk);
    x_in = 14'sd2000; y_in = -14'sd2000;
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_x_out", 32'($signed(x_out)), 0);
    chk("midrst_y_out", 32'($signed(y_out)), 0);
    chk("midrst_sat_out", 32'(sat_out), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("postrst_no_beat", 32'(out_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gain_comp_pipe.md
GAIN_COMP_PIPE -- requirements
Module: gain_comp_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, giving the signed sample width of every data port.
REQ-002 SHALL have parameter GUARD_BITS, default 4, giving the fraction bits kept below the LSB during accumulation.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input beat present.
REQ-006 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-007 SHALL have ports x_in and y_in, input, DATA_WIDTH each, signed two's-complement CORDIC outputs.
REQ-008 SHALL have port mode, input, 2, per-beat gain mode sampled with the beat: 00 bypass, 01 compensate (x0.6072998), 10 compensate x2 (x1.2145996), 11 treated as bypass.
REQ-009 SHALL have port out_valid, output, 1, output beat present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the beat.
REQ-011 SHALL have ports x_out and y_out, output, DATA_WIDTH each, signed scaled results.
REQ-012 SHALL have port sat_out, output, 1, set when either channel of the current output beat was clipped.

Function
REQ-013 Compensate gain SHALL be the fixed shift-sum 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13; compensate x2 SHALL use the same terms with every shift reduced by one.
REQ-014 Each channel SHALL be sign-extended and left-shifted by GUARD_BITS, each term formed by arithmetic right shift (floor), and terms summed at DATA_WIDTH+GUARD_BITS+2 bits with no intermediate overflow.
REQ-015 Rounding SHALL add 2^(GUARD_BITS-1) then arithmetic-shift right by GUARD_BITS (round half toward +inf).
REQ-016 Rounded results outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] SHALL saturate to the nearest bound, and sat_out SHALL be set for that beat.
REQ-017 Bypass SHALL pass x_in/y_in unchanged with sat_out 0, through the same pipeline and latency.
REQ-018 Pipeline SHALL be two register stages: stage 1 holds positive-term and negative-term partial sums plus mode; stage 2 holds rounded, saturated outputs; latency exactly 2 cycles with out_ready held high.
REQ-019 A beat SHALL transfer at input when in_valid && in_ready and at output when out_valid && out_ready.
REQ-020 Pipeline advance enable SHALL be (!out_valid || out_ready); in_ready SHALL equal that enable; throughput one beat per cycle.
REQ-021 While out_valid && !out_ready, x_out, y_out, sat_out and out_valid SHALL remain stable and no beat SHALL be dropped or duplicated.
REQ-022 Empty stages (bubbles) SHALL collapse when the enable is high; stage valids track occupancy independently.
REQ-023 Beats SHALL leave in arrival order; mode changes between beats SHALL apply per beat with no flush.

Reset
REQ-024 On rst, all stage valid bits, out_valid, x_out, y_out and sat_out SHALL become 0 immediately.
REQ-025 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-026 Shared package cordic_pkg SHALL hold the mode enum, the term-count constant (5), and the term shift/sign table.
REQ-027 One sub-module gain_comp_lane SHALL implement a single channel's term sum, rounding and saturation, instantiated twice (x, y); handshake and valid logic SHALL live in gain_comp_pipe only.

Verification
REQ-028 mode 01, x_in 8192 (after width extension), y_in -8192, DATA_WIDTH 16 -> x_out 4975, y_out -4975, sat_out 0, two cycles later.
REQ-029 mode 01, x_in 1000, y_in -1000 -> x_out 607, y_out -607, sat_out 0.
REQ-030 mode 10, x_in 8191, y_in -8192 (DATA_WIDTH 14) -> x_out 8191, y_out -8192, sat_out 1.
REQ-031 mode 00 and 11, x_in 1234, y_in -5 -> outputs 1234, -5, sat_out 0.
REQ-032 Stream of 20 beats with mixed modes, out_ready toggled pseudo-randomly -> all 20 results in order, held stable during stalls, none lost.
REQ-033 rst asserted with two beats in flight -> out_valid 0 same cycle, neither beat ever emitted, in_ready 1 after release.
